// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - iterative multi-length AES key expansion with registered round-key read port

// FIPS-197 forward S-box, one byte in, one byte out, purely combinational.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_s = SBOX[{i_a, 3'b000} +: 8];

endmodule

// Sequential key schedule: one 32-bit word W[i] produced per clock into a word store.
module aes_key_schedule_seq #(
    parameter int NK_MAX = 8,
    parameter int RKW    = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [0:32*NK_MAX-1]  key,
    output logic                  busy,
    output logic                  done,
    output logic                  ready,
    output logic [3:0]            num_rounds,
    output logic                  err,
    input  logic                  rk_rd_en,
    input  logic [3:0]            rk_idx,
    output logic                  rk_valid,
    output logic [0:RKW-1]        rk
);

    localparam int DEPTH = 4 * (NK_MAX + 7);
    localparam int KIW   = $clog2(NK_MAX);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [31:0]  r_w [DEPTH];
    logic [5:0]   r_i;
    logic [2:0]   r_mod;
    logic [7:0]   r_rcon;
    logic [3:0]   r_nk;
    logic [5:0]   r_last;
    logic         r_busy;
    logic         r_done;
    logic         r_ready;
    logic [3:0]   r_num_rounds;
    logic         r_err;
    logic         r_rk_valid;
    logic [RKW-1:0] r_rk;

    logic         w_accept;
    logic         w_err;
    logic         w_step;
    logic         w_last;
    logic [3:0]   w_nk_new;
    logic [3:0]   w_nr_new;
    logic [5:0]   w_last_new;
    logic [31:0]  w_key_word [NK_MAX];
    logic [5:0]   w_idx_prev;
    logic [5:0]   w_idx_back;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_new;
    logic [2:0]   w_mod_last;
    logic         w_rd_ok;
    logic [5:0]   w_rd_base;

    assign busy       = r_busy;
    assign done       = r_done;
    assign ready      = r_ready;
    assign num_rounds = r_num_rounds;
    assign err        = r_err;
    assign rk_valid   = r_rk_valid;
    assign rk         = r_rk;

    for (genvar g = 0; g < NK_MAX; g++) begin : g_key_word
        assign w_key_word[g] = key[32*g +: 32];
    end

    // Key length decode: words in the key, round count and index of the final schedule word.
    always_comb begin
        w_nk_new   = 4'd4;
        w_nr_new   = 4'd10;
        w_last_new = 6'd43;
        case (key_len)
            2'd1: begin
                w_nk_new   = 4'd6;
                w_nr_new   = 4'd12;
                w_last_new = 6'd51;
            end
            2'd2: begin
                w_nk_new   = 4'd8;
                w_nr_new   = 4'd14;
                w_last_new = 6'd59;
            end
            default: ;
        endcase
    end

    // Previous word and word Nk back; RotWord only on the i%Nk==0 step, S-boxes shared by both cases.
    assign w_idx_prev = r_i - 6'd1;
    assign w_idx_back = r_i - {2'b00, r_nk};
    assign w_prev     = r_w[w_idx_prev];
    assign w_back     = r_w[w_idx_back];
    assign w_sub_in   = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sbox u_sbox0 (.i_a(w_sub_in[31:24]), .o_s(w_sub[31:24]));
    aes_sbox u_sbox1 (.i_a(w_sub_in[23:16]), .o_s(w_sub[23:16]));
    aes_sbox u_sbox2 (.i_a(w_sub_in[15:8]),  .o_s(w_sub[15:8]));
    aes_sbox u_sbox3 (.i_a(w_sub_in[7:0]),   .o_s(w_sub[7:0]));

    // Select the mixing term t for the current word position within the key-length period.
    always_comb begin
        w_t = w_prev;
        if (r_mod == 3'd0) begin
            w_t = w_sub ^ {r_rcon, 24'h000000};
        end else if (r_nk == 4'd8 && r_mod == 3'd4) begin
            w_t = w_sub;
        end
    end

    assign w_new      = w_back ^ w_t;
    assign w_mod_last = 3'(r_nk - 4'd1);

    // Next-state logic and single-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (key_len == 2'd3) begin
                        w_err = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                w_step = 1'b1;
                if (r_i == r_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Expansion bookkeeping and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_i          <= 6'd0;
            r_mod        <= 3'd0;
            r_rcon       <= 8'h01;
            r_nk         <= 4'd4;
            r_last       <= 6'd43;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b0;
            r_num_rounds <= 4'd0;
            r_err        <= 1'b0;
        end else begin
            r_done <= w_last;
            r_err  <= w_err;
            if (w_accept) begin
                r_i          <= {2'b00, w_nk_new};
                r_mod        <= 3'd0;
                r_rcon       <= 8'h01;
                r_nk         <= w_nk_new;
                r_last       <= w_last_new;
                r_num_rounds <= w_nr_new;
                r_ready      <= 1'b0;
                r_busy       <= 1'b1;
            end else if (w_step) begin
                r_i   <= r_i + 6'd1;
                r_mod <= (r_mod == w_mod_last) ? 3'd0 : r_mod + 3'd1;
                if (r_mod == 3'd0) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
                if (w_last) begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            end
        end
    end

    // Word store: key words at accept, one expanded word per EXPAND cycle; contents not reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (w_accept) begin
                for (int j = 0; j < NK_MAX; j++) begin
                    if (j < int'(w_nk_new)) begin
                        r_w[6'(j)] <= w_key_word[KIW'(j)];
                    end
                end
            end else if (w_step) begin
                r_w[r_i] <= w_new;
            end
        end
    end

    assign w_rd_ok   = rk_rd_en && r_ready && (rk_idx <= r_num_rounds);
    assign w_rd_base = {rk_idx, 2'b00};

    // Registered round-key read; rk holds its last value when no read is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rk_valid <= 1'b0;
            r_rk       <= '0;
        end else begin
            r_rk_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rk <= {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                         r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb/tb_aes_key_schedule_seq.sv - directed self-checking bench for aes_key_schedule_seq

module tb_aes_key_schedule_seq;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         ready;
    logic [3:0]   num_rounds;
    logic         err;
    logic         rk_rd_en;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_out;

    int n_checks;
    int n_errors;

    aes_key_schedule_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .key_len    (key_len),
        .key        (key_in),
        .busy       (busy),
        .done       (done),
        .ready      (ready),
        .num_rounds (num_rounds),
        .err        (err),
        .rk_rd_en   (rk_rd_en),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk         (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic read_rk(input logic [3:0] idx);
        rk_rd_en = 1'b1;
        rk_idx   = idx;
        tick();
        rk_rd_en = 1'b0;
    endtask

    task automatic run_expand(input string tag, input logic [1:0] kl, input logic [255:0] kv,
                              input int exp_lat, input logic [3:0] exp_nr, input bit mid_pulse);
        int lat;
        lat     = -1;
        key_len = kl;
        key_in  = kv;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_accept_flags"}, 128'({busy, ready, done}), 128'(3'b100));
        chk({tag, "_accept_nr"}, 128'(num_rounds), 128'(exp_nr));
        for (int n = 1; n <= 200; n++) begin
            if (mid_pulse && n == 10) begin
                start   = 1'b1;
                key_len = 2'd2;
                key_in  = KEY256;
            end
            if (mid_pulse && n == 11) begin
                start   = 1'b0;
                key_len = kl;
                key_in  = kv;
            end
            tick();
            if (n == 20) begin
                chk({tag, "_mid_flags"}, 128'({busy, ready, done}), 128'(3'b100));
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_done_flags"}, 128'({busy, ready}), 128'(2'b01));
        chk({tag, "_done_nr"}, 128'(num_rounds), 128'(exp_nr));
        tick();
        chk({tag, "_done_pulse_end"}, 128'(done), 128'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        key_len  = 2'd0;
        key_in   = '0;
        rk_rd_en = 1'b0;
        rk_idx   = 4'd0;
        tick();
        tick();
        chk("reset_flags", 128'({busy, done, ready, err, rk_valid}), 128'd0);
        chk("reset_nr", 128'(num_rounds), 128'd0);
        chk("reset_rk", rk_out, 128'd0);
        reset_n = 1'b1;
        tick();

        read_rk(4'd0);
        chk("read_not_ready", 128'(rk_valid), 128'd0);

        run_expand("aes128", 2'd0, KEY128, 40, 4'd10, 1'b1);

        rk_rd_en = 1'b1;
        rk_idx   = 4'd0;
        tick();
        chk("a128_rk0_valid", 128'(rk_valid), 128'd1);
        chk("a128_rk0", rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rk_idx = 4'd10;
        tick();
        chk("a128_rk10_valid", 128'(rk_valid), 128'd1);
        chk("a128_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk_idx = 4'd1;
        tick();
        chk("a128_rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
        rk_idx = 4'd11;
        tick();
        rk_rd_en = 1'b0;
        chk("a128_rk11_valid", 128'(rk_valid), 128'd0);
        chk("a128_rk11_hold", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);

        key_len = 2'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        key_len = 2'd0;
        chk("illegal_err", 128'(err), 128'd1);
        chk("illegal_flags", 128'({busy, ready}), 128'(2'b01));
        chk("illegal_nr", 128'(num_rounds), 128'd10);
        tick();
        chk("illegal_err_end", 128'(err), 128'd0);
        read_rk(4'd10);
        chk("illegal_rk10_kept", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_expand("aes192", 2'd1, KEY192, 46, 4'd12, 1'b0);
        read_rk(4'd12);
        chk("a192_rk12", rk_out, 128'he98ba06f448c773c8ecc720401002202);
        read_rk(4'd1);
        chk("a192_rk1", rk_out, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);

        run_expand("aes256", 2'd2, KEY256, 52, 4'd14, 1'b0);
        read_rk(4'd14);
        chk("a256_rk14", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(4'd2);
        chk("a256_rk2", rk_out, 128'h9ba354118e6925afa51a8b5f2067fcde);

        run_expand("aes128b", 2'd0, KEY128, 40, 4'd10, 1'b0);
        read_rk(4'd10);
        chk("a128b_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4'd14);
        chk("a128b_rk14_reject", 128'(rk_valid), 128'd0);

        key_len = 2'd0;
        key_in  = KEY128;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 20; n++) begin
            tick();
        end
        chk("abort_busy_before", 128'(busy), 128'd1);
        reset_n = 1'b0;
        tick();
        chk("abort_flags", 128'({busy, ready, done}), 128'd0);
        chk("abort_nr", 128'(num_rounds), 128'd0);
        reset_n = 1'b1;
        tick();
        chk("abort_idle", 128'({busy, done}), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
